uart_rxx: RTL

- UART receiver, the receive-side counterpart of the team's uart_txx transmitter.
- Frame format: 8N1, LSB first, idle high. Both blocks use the same clks_per_bit.
- Oversamples the serial line on clk, samples each bit at mid-bit, and presents the received byte with a one-cycle valid pulse.
- Detects framing errors on the stop bit.

---
 rtl/uart_rxx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rxx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with a 2-flop synchronizer.
// Define UART_RX_PARITY_EN for 8E1 frames with an o_parity_err pulse.
module uart_rxx #(
    parameter int unsigned clks_per_bit = 543
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_databyte,
    output logic       o_data_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_active
);

    localparam logic [15:0] LAST = 16'(clks_per_bit - 1);
    localparam logic [15:0] HALF = 16'((clks_per_bit - 1) / 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif

    logic [1:0]  sync_q;
    logic        rx_s;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    // a start bit gone by mid-bit is line noise
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    shift_d[bit_q] = rx_s;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == LAST) begin
                    // back to idle mid stop bit so a zero-gap start is caught
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], i_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign o_databyte   = byte_q;
    assign o_data_valid = valid_q;
    assign o_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif
    assign o_active = (state_q == S_START) || (state_q == S_DATA) ||
`ifdef UART_RX_PARITY_EN
                      (state_q == S_PAR) ||
`endif
                      (state_q == S_STOP);

endmodule
